// File: rtl/fc_primitive_tx.sv
// fc_primitive_tx: FC transmit word mux choosing between frame words and port-state primitives.
// Optional aborted-frame counter enabled by defining FC_TX_ABORT_CNT_EN.
package fc;
  typedef enum logic [3:0] {AC, LR1, LR2, LR3, LF1, LF2, OL1, OL2, OL3} state_t;
endpackage

module fc_primitive_tx (
  input  logic        clk,
  input  logic        reset,
  input  fc::state_t  state,
  input  logic        is_active,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic        in_ready,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_datak
`ifdef FC_TX_ABORT_CNT_EN
  ,
  output logic [15:0] abort_count
`endif
);
  localparam logic [31:0] P_IDLE = 32'hBC95B5B5;
  localparam logic [31:0] P_LR   = 32'hBC49BF49;
  localparam logic [31:0] P_LRR  = 32'hBC35BF49;
  localparam logic [31:0] P_OLS  = 32'hBC358A55;
  localparam logic [31:0] P_NOS  = 32'hBC55BF45;
  typedef enum logic [1:0] {GAP, READY, FRAME, DROP} fsm_t;
  fsm_t        fsm_q, fsm_d;
  logic [2:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] tx_data_q, tx_data_d, prim;
  logic [3:0]  tx_datak_q, tx_datak_d;
  logic        acc, fwd;
  always_comb begin
    case (state)
      fc::LR1, fc::OL2: prim = P_LR;
      fc::LR2:          prim = P_LRR;
      fc::LF1, fc::OL1: prim = P_OLS;
      fc::LF2, fc::OL3: prim = P_NOS;
      default:          prim = P_IDLE;
    endcase
  end
  assign in_ready = (fsm_q == DROP) || ((fsm_q inside {READY, FRAME}) && is_active);
  assign acc      = in_valid && in_ready;
  // GAP always emits a primitive, so gap_cnt_q==5 means the sixth gap word goes out this cycle
  always_comb begin
    fsm_d = fsm_q;
    fwd   = 1'b0;
    case (fsm_q)
      GAP:   fsm_d = (gap_cnt_q >= 3'd5 && is_active) ? READY : GAP;
      READY: begin
        fwd   = acc && in_startofpacket;
        fsm_d = fwd ? (in_endofpacket ? GAP : FRAME) : READY;
      end
      FRAME: begin
        fwd   = acc;
        fsm_d = !is_active ? DROP : (acc && in_endofpacket) ? GAP : FRAME;
      end
      DROP:    fsm_d = (acc && in_endofpacket) ? GAP : DROP;
      default: fsm_d = GAP;
    endcase
  end
  always_comb begin
    gap_cnt_d  = (acc && in_endofpacket) ? 3'd0 :
                 (!fwd && gap_cnt_q != 3'd6) ? gap_cnt_q + 3'd1 : gap_cnt_q;
    tx_data_d  = fwd ? in_data : prim;
    tx_datak_d = fwd ? in_datak : 4'b1000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= GAP;
      gap_cnt_q  <= 3'd0;
      tx_data_q  <= P_NOS;
      tx_datak_q <= 4'b1000;
    end else begin
      fsm_q      <= fsm_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_datak_q <= tx_datak_d;
    end
  end
  assign tx_data  = tx_data_q;
  assign tx_datak = tx_datak_q;
`ifdef FC_TX_ABORT_CNT_EN
  logic [15:0] abort_count_q, abort_count_d;
  always_comb begin
    abort_count_d = (fsm_q == FRAME && fsm_d == DROP && abort_count_q != 16'hFFFF) ?
                    abort_count_q + 16'd1 : abort_count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) abort_count_q <= 16'd0;
    else abort_count_q <= abort_count_d;
  end
  assign abort_count = abort_count_q;
`endif
endmodule

// File: tb/tb_fc_primitive_tx.sv
// tb_fc_primitive_tx: randomized scenario bench for fc_primitive_tx with a stream-level reference model.
module tb_fc_primitive_tx;
  localparam logic [31:0] P_IDLE = 32'hBC95B5B5;
  localparam logic [31:0] P_LR   = 32'hBC49BF49;
  localparam logic [31:0] P_LRR  = 32'hBC35BF49;
  localparam logic [31:0] P_OLS  = 32'hBC358A55;
  localparam logic [31:0] P_NOS  = 32'hBC55BF45;
  logic        clk = 1'b0, reset = 1'b1, is_active = 1'b0;
  fc::state_t  state = fc::AC;
  logic [31:0] in_data = '0;
  logic [3:0]  in_datak = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic        in_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_datak;
`ifdef FC_TX_ABORT_CNT_EN
  logic [15:0] abort_count;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic        v, sop, eop, rdy;
    logic [31:0] d, tx;
    logic [3:0]  k, txk;
  } cyc_t;
  cyc_t sched[$];

  fc_primitive_tx dut (
    .clk(clk), .reset(reset), .state(state), .is_active(is_active),
    .in_data(in_data), .in_datak(in_datak), .in_valid(in_valid),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_ready(in_ready),
    .tx_data(tx_data), .tx_datak(tx_datak)
`ifdef FC_TX_ABORT_CNT_EN
    , .abort_count(abort_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] prim_of(fc::state_t s);
    case (s)
      fc::LR1: return P_LR;
      fc::LR2: return P_LRR;
      fc::LR3: return P_IDLE;
      fc::LF1: return P_OLS;
      fc::LF2: return P_NOS;
      fc::OL1: return P_OLS;
      fc::OL2: return P_LR;
      fc::OL3: return P_NOS;
      default: return P_IDLE;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] d, input logic [3:0] k,
                     input logic sop, input logic eop);
    in_valid = v; in_data = d; in_datak = k; in_sop = sop; in_eop = eop;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    put(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    is_active = 1'b0;
    state = fc::AC;
    do_reset();
    n_chk++;
    if (tx_data !== P_NOS) begin n_fail++; $display("FAIL reset_tx tx_data=%h exp %h", tx_data, P_NOS); end
    n_chk++;
    if (tx_datak !== 4'b1000) begin n_fail++; $display("FAIL reset_txk tx_datak=%b exp 1000", tx_datak); end
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready in_ready=%b exp 0", in_ready); end
`ifdef FC_TX_ABORT_CNT_EN
    n_chk++;
    if (abort_count !== 16'd0) begin n_fail++; $display("FAIL reset_abort abort_count=%0d exp 0", abort_count); end
`endif
  endtask

  task automatic test_prims();
    fc::state_t seq[$];
    seq = '{fc::LF2, fc::OL2, fc::LR2};
    repeat (20) seq.push_back(fc::state_t'(4'($urandom_range(0, 8))));
    is_active = 1'b0;
    do_reset();
    foreach (seq[i]) begin
      state = seq[i];
      tick();
      n_chk++;
      if (tx_data !== prim_of(seq[i]) || tx_datak !== 4'b1000)
        begin n_fail++; $display("FAIL prim step %0d state=%s tx=%h/%b exp %h/1000", i, seq[i].name(), tx_data, tx_datak, prim_of(seq[i])); end
      n_chk++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prim_ready step %0d in_ready=%b exp 0", i, in_ready); end
    end
  endtask

  task automatic test_frames(input int nframes);
    sched.delete();
    for (int f = 0; f < nframes; f++) begin
      int len;
      logic [31:0] w[$];
      logic [3:0]  wk[$];
      len = (f == 0) ? 3 : (f < 3) ? 2 : $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        w.push_back($urandom);
        wk.push_back(4'($urandom));
      end
      for (int g = 0; g < 6; g++)
        sched.push_back('{v:1'b1, sop:1'b1, eop:(len == 1), rdy:1'b0, d:w[0], tx:P_IDLE, k:wk[0], txk:4'b1000});
      for (int i = 0; i < len; i++) begin
        int gaps;
        gaps = (i == 0 || f < 2) ? 0 : (f == 2) ? 2 : $urandom_range(0, 2);
        repeat (gaps)
          sched.push_back('{v:1'b0, sop:1'b0, eop:1'b0, rdy:1'b1, d:$urandom, tx:P_IDLE, k:4'b0, txk:4'b1000});
        sched.push_back('{v:1'b1, sop:(i == 0), eop:(i == len - 1), rdy:1'b1, d:w[i], tx:w[i], k:wk[i], txk:wk[i]});
      end
    end
    for (int g = 0; g < 6; g++)
      sched.push_back('{v:1'b0, sop:1'b0, eop:1'b0, rdy:1'b0, d:'0, tx:P_IDLE, k:4'b0, txk:4'b1000});
    sched.push_back('{v:1'b0, sop:1'b0, eop:1'b0, rdy:1'b1, d:'0, tx:P_IDLE, k:4'b0, txk:4'b1000});
    state = fc::AC;
    is_active = 1'b1;
    do_reset();
    foreach (sched[c]) begin
      put(sched[c].v, sched[c].d, sched[c].k, sched[c].sop, sched[c].eop);
      n_chk++;
      if (in_ready !== sched[c].rdy)
        begin n_fail++; $display("FAIL frames_ready cyc %0d in_ready=%b exp %b", c, in_ready, sched[c].rdy); end
      tick();
      n_chk++;
      if (tx_data !== sched[c].tx || tx_datak !== sched[c].txk)
        begin n_fail++; $display("FAIL frames_tx cyc %0d tx=%h/%b exp %h/%b", c, tx_data, tx_datak, sched[c].tx, sched[c].txk); end
    end
  endtask

  task automatic test_nonsop();
    logic [31:0] w;
    state = fc::AC;
    is_active = 1'b1;
    do_reset();
    repeat (6) begin put(1'b0, '0, '0, 1'b0, 1'b0); tick(); end
    put(1'b1, 32'h1234_5678, 4'b0, 1'b0, 1'b0);
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nonsop_ready in_ready=%b exp 1", in_ready); end
    tick();
    n_chk++;
    if (tx_data !== P_IDLE) begin n_fail++; $display("FAIL nonsop_tx tx_data=%h exp %h", tx_data, P_IDLE); end
    w = $urandom;
    put(1'b1, w, 4'b1000, 1'b1, 1'b1);
    tick();
    n_chk++;
    if (tx_data !== w || tx_datak !== 4'b1000) begin n_fail++; $display("FAIL nonsop_next tx=%h exp %h", tx_data, w); end
  endtask

  task automatic test_drop();
    logic [31:0] w[5];
    foreach (w[i]) w[i] = $urandom;
    state = fc::AC;
    is_active = 1'b1;
    do_reset();
    repeat (6) begin put(1'b0, '0, '0, 1'b0, 1'b0); tick(); end
    for (int i = 0; i < 2; i++) begin put(1'b1, w[i], 4'b0, i == 0, 1'b0); tick(); end
    n_chk++;
    if (tx_data !== w[1]) begin n_fail++; $display("FAIL drop_pre tx_data=%h exp %h", tx_data, w[1]); end
    is_active = 1'b0;
    state = fc::LR1;
    for (int i = 2; i < 5; i++) begin
      put(1'b1, w[i], 4'b0, 1'b0, i == 4);
      if (i == 2) begin
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready0 in_ready=%b exp 0", in_ready); end
        tick();
        n_chk++;
        if (tx_data !== P_LR) begin n_fail++; $display("FAIL drop_first tx_data=%h exp %h", tx_data, P_LR); end
        put(1'b1, w[i], 4'b0, 1'b0, 1'b0);
      end
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready word %0d in_ready=%b exp 1", i + 1, in_ready); end
      tick();
      n_chk++;
      if (tx_data !== P_LR) begin n_fail++; $display("FAIL drop_tx word %0d tx_data=%h exp %h", i + 1, tx_data, P_LR); end
    end
    put(1'b0, '0, '0, 1'b0, 1'b0);
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drop_end_ready in_ready=%b exp 0", in_ready); end
`ifdef FC_TX_ABORT_CNT_EN
    n_chk++;
    if (abort_count !== 16'd1) begin n_fail++; $display("FAIL drop_abort abort_count=%0d exp 1", abort_count); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    state = fc::AC;
    is_active = 1'b1;
    do_reset();
    repeat (6) begin put(1'b0, '0, '0, 1'b0, 1'b0); tick(); end
    put(1'b1, $urandom, 4'b1000, 1'b1, 1'b0); tick();
    put(1'b1, $urandom, 4'b0, 1'b0, 1'b0); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    put(1'b1, $urandom, 4'b0, 1'b0, 1'b0);
    n_chk++;
    if (tx_data !== P_NOS || tx_datak !== 4'b1000) begin n_fail++; $display("FAIL midreset_tx tx=%h/%b exp %h/1000", tx_data, tx_datak, P_NOS); end
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready in_ready=%b exp 0", in_ready); end
`ifdef FC_TX_ABORT_CNT_EN
    n_chk++;
    if (abort_count !== 16'd0) begin n_fail++; $display("FAIL midreset_abort abort_count=%0d exp 0", abort_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_prims();
    test_frames(8);
    test_nonsop();
    test_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_primitive_tx.md
FC_PRIMITIVE_TX -- requirements
Module: fc_primitive_tx

Interface
REQ-001 SHALL: clk  input  1  single clock for all logic.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: state  input  fc::state_t  current FC_Port state from the RX state machine.
REQ-004 SHALL: is_active  input  1  high once Active State is entered and the 6-IDLE hold-off has elapsed.
REQ-005 SHALL: in_data  input  32  frame word, including SOF/EOF ordered sets, from the frame source.
REQ-006 SHALL: in_datak  input  4  K-flags for in_data.
REQ-007 SHALL: in_valid, in_startofpacket, in_endofpacket  input  1 each  streaming handshake qualifiers.
REQ-008 SHALL: in_ready  output  1  frame word accepted when in_valid && in_ready.
REQ-009 SHALL: tx_data  output  32  transmission word to the PHY/encoder.
REQ-010 SHALL: tx_datak  output  4  K-flags for tx_data.
REQ-011 SHALL: abort_count  output  16  aborted-frame counter, present only under FC_TX_ABORT_CNT_EN.

Function
REQ-012 SHALL: Primitive encodings, with tx_datak=4'b1000, are: IDLE 0xBC95B5B5, LR 0xBC49BF49, LRR 0xBC35BF49, OLS 0xBC358A55, NOS 0xBC55BF45.
REQ-013 SHALL: Per-state primitive: LR1->LR, LR2->LRR, LR3->IDLE, LF1->OLS, LF2->NOS, OL1->OLS, OL2->LR, OL3->NOS, AC->IDLE whenever no frame word is sent.
REQ-014 SHALL: tx_data/tx_datak are registered; a word accepted, or a state sampled, on cycle N appears on cycle N+1.
REQ-015 SHALL: The FSM has four states: GAP, READY, FRAME, DROP.
REQ-016 SHALL: gap_cnt (3 bits) counts primitive words emitted since the last EOF; it saturates at 6 and clears to 0 on acceptance of an eop word.
REQ-017 SHALL: GAP->READY when gap_cnt==6 and is_active; in_ready=0 in GAP.
REQ-018 SHALL: READY: in_ready=is_active; an accepted word with sop moves to FRAME and is forwarded; an accepted word without sop is discarded, with IDLE emitted.
REQ-019 SHALL: FRAME: in_ready=is_active; accepted words are forwarded verbatim; an eop word returns the FSM to GAP; in_valid low emits IDLE (underrun) and stays in FRAME.
REQ-020 SHALL: A word with both sop and eop accepted in READY is forwarded and returns the FSM to GAP.
REQ-021 SHALL: is_active falling in FRAME moves the FSM to DROP the same cycle; no further frame words are forwarded, and the output follows REQ-013.
REQ-022 SHALL: DROP: in_ready=1; all words are discarded; an accepted eop word moves the FSM to GAP; abort_count increments once on entry to DROP.
REQ-023 SHALL: Whenever is_active=0, READY is held (no transition to FRAME) and the output follows REQ-013.
REQ-024 SHALL: in_ready is derived only from registered state and is_active, never from in_valid.
REQ-025 SHALL: abort_count saturates at 0xFFFF.

Reset
REQ-026 SHALL: On reset: FSM=GAP, gap_cnt=0, tx_data=0xBC55BF45 (NOS), tx_datak=4'b1000, abort_count=0, in_ready=0.
REQ-027 SHALL: Reset asserted mid-frame discards the frame without incrementing abort_count; after reset, upstream resynchronises by waiting for the next sop.

Configuration
REQ-028 SHALL: Macro FC_TX_ABORT_CNT_EN defined: the abort_count port and counter exist per REQ-022/025.
REQ-029 SHALL: Macro FC_TX_ABORT_CNT_EN undefined: no abort_count port or counter; all other behaviour is identical.

Verification
REQ-030 SHALL: state=LF2 held, then OL2, then LR2 -> tx_data is NOS, then LR, then LRR, each one cycle after the change.
REQ-031 SHALL: state=AC, is_active=1 from reset, then 3-word frame (sop..eop) offered -> 6 IDLEs first, then 3 words verbatim with 1-cycle latency.
REQ-032 SHALL: Two back-to-back 2-word frames offered continuously -> exactly 6 IDLEs between first EOF and second SOF, with in_ready=0 during the gap.
REQ-033 SHALL: is_active drops after word 2 of a 5-word frame, with state=LR1 -> tx_data=LR from the next cycle, words 3..5 consumed and not forwarded, abort_count=1.
REQ-034 SHALL: in_valid low for 2 cycles mid-frame -> 2 IDLEs inserted and the frame completes normally; a non-sop word offered in READY -> discarded, IDLE out.
REQ-035 SHALL: Reset asserted mid-frame -> next cycle tx_data=0xBC55BF45, in_ready=0, abort_count=0.
